// File: rtl/router_local_endpoint.sv
// Credit-based LOCAL-port endpoint: TX FIFO with downstream credit tracking, RX FIFO with per-pop credit return.
// Optional flit statistics counters are enabled by defining ROUTER_ENDPOINT_STATS_EN.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif

module router_local_endpoint #(
    parameter int DATA_WIDTH = `ROUTER_WIDTH,
    parameter int CREDIT_NUM = 4,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  out_data_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_credit,
    input  logic                  in_data_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_credit,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    output logic                  err_rx_overflow,
    output logic                  err_credit_overflow,
    output logic [15:0]           tx_flit_cnt,
    output logic [15:0]           rx_flit_cnt
);

    localparam int TX_AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int TX_CW = $clog2(TX_DEPTH + 1);
    localparam int RX_AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int RX_CW = $clog2(RX_DEPTH + 1);
    localparam int CR_W  = $clog2(CREDIT_NUM + 1);

    logic [DATA_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
    logic [TX_CW-1:0]      tx_cnt;
    logic [CR_W-1:0]       credit;
    logic                  tx_push, launch;

    logic [DATA_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;
    logic [RX_CW-1:0]      rx_cnt;
    logic                  rx_full, rx_push, rx_pop, rx_drop;

    // Credit update saturates at CREDIT_NUM; a simultaneous launch and return cancel out.
    function automatic logic [CR_W-1:0] credit_next(input logic [CR_W-1:0] cur,
                                                     input logic dec, input logic inc);
        logic [CR_W-1:0] nxt;
        nxt = cur;
        if (dec && !inc)
            nxt = cur - 1'b1;
        else if (inc && !dec && cur != CR_W'(CREDIT_NUM))
            nxt = cur + 1'b1;
        return nxt;
    endfunction

    assign tx_ready = (tx_cnt != TX_CW'(TX_DEPTH));
    assign tx_push  = tx_valid && tx_ready;
    // Launch looks only at registered occupancy, so a flit is never bypassed into out_data.
    assign launch   = (tx_cnt != '0) && (credit != '0);

    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_mem[rx_rd_ptr];
    assign rx_full  = (rx_cnt == RX_CW'(RX_DEPTH));
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = in_data_valid && (!rx_full || rx_pop);
    assign rx_drop  = in_data_valid && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= tx_data;
        if (rx_push)
            rx_mem[rx_wr_ptr] <= in_data;
    end

    // TX side: FIFO pointers, credit counter and registered router output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr           <= '0;
            tx_rd_ptr           <= '0;
            tx_cnt              <= '0;
            credit              <= CR_W'(CREDIT_NUM);
            out_data_valid      <= 1'b0;
            out_data            <= '0;
            err_credit_overflow <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= (tx_wr_ptr == TX_AW'(TX_DEPTH - 1)) ? '0 : tx_wr_ptr + 1'b1;
            if (launch) begin
                tx_rd_ptr <= (tx_rd_ptr == TX_AW'(TX_DEPTH - 1)) ? '0 : tx_rd_ptr + 1'b1;
                out_data  <= tx_mem[tx_rd_ptr];
            end
            out_data_valid <= launch;
            case ({tx_push, launch})
                2'b10:   tx_cnt <= tx_cnt + 1'b1;
                2'b01:   tx_cnt <= tx_cnt - 1'b1;
                default: tx_cnt <= tx_cnt;
            endcase
            credit <= credit_next(credit, launch, out_credit);
            if (out_credit && !launch && credit == CR_W'(CREDIT_NUM))
                err_credit_overflow <= 1'b1;
        end
    end

    // RX side: FIFO pointers, overflow flag and credit return pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            rx_cnt          <= '0;
            in_credit       <= 1'b0;
            err_rx_overflow <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= (rx_wr_ptr == RX_AW'(RX_DEPTH - 1)) ? '0 : rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= (rx_rd_ptr == RX_AW'(RX_DEPTH - 1)) ? '0 : rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + 1'b1;
                2'b01:   rx_cnt <= rx_cnt - 1'b1;
                default: rx_cnt <= rx_cnt;
            endcase
            in_credit <= rx_pop;
            if (rx_drop)
                err_rx_overflow <= 1'b1;
        end
    end

`ifdef ROUTER_ENDPOINT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_flit_cnt <= '0;
            rx_flit_cnt <= '0;
        end else begin
            if (launch)
                tx_flit_cnt <= tx_flit_cnt + 1'b1;
            if (rx_pop)
                rx_flit_cnt <= rx_flit_cnt + 1'b1;
        end
    end
`else
    assign tx_flit_cnt = '0;
    assign rx_flit_cnt = '0;
`endif

endmodule

// File: tb/tb_router_local_endpoint.sv
// Directed bench for router_local_endpoint: credit flow, RX round trip, overflow flags, async reset, stats.
module tb_router_local_endpoint;

    localparam int DW = 16;
`ifdef ROUTER_ENDPOINT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_valid, tx_ready, out_data_valid, out_credit;
    logic [DW-1:0] tx_data, out_data, in_data, rx_data;
    logic          in_data_valid, in_credit, rx_valid, rx_ready;
    logic          err_rx_overflow, err_credit_overflow;
    logic [15:0]   tx_flit_cnt, rx_flit_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    router_local_endpoint #(
        .DATA_WIDTH (DW),
        .CREDIT_NUM (4),
        .TX_DEPTH   (4),
        .RX_DEPTH   (4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tx_valid            (tx_valid),
        .tx_data             (tx_data),
        .tx_ready            (tx_ready),
        .out_data_valid      (out_data_valid),
        .out_data            (out_data),
        .out_credit          (out_credit),
        .in_data_valid       (in_data_valid),
        .in_data             (in_data),
        .in_credit           (in_credit),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .rx_ready            (rx_ready),
        .err_rx_overflow     (err_rx_overflow),
        .err_credit_overflow (err_credit_overflow),
        .tx_flit_cnt         (tx_flit_cnt),
        .rx_flit_cnt         (rx_flit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_valid = 1'b0; tx_data = '0; out_credit = 1'b0;
        in_data_valid = 1'b0; in_data = '0; rx_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Push n flits base, base+1, ... with no credit returns; check launch order and count pulses.
    task automatic run_tx(input int n, input int cycles, input logic [15:0] base, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tx_valid = (i < n);
            tx_data  = base + 16'(i);
            tick();
            if (out_data_valid) begin
                chk("tx_order", 32'(out_data), 32'(base + 16'(pulses)));
                pulses++;
            end
        end
        tx_valid = 1'b0;
    endtask

    int pulses;

    initial begin
        do_reset();
        chk("rst_out_valid", 32'(out_data_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_credit", 32'(in_credit), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_err_rx", 32'(err_rx_overflow), 0);
        chk("rst_err_cr", 32'(err_credit_overflow), 0);
        chk("rst_tx_cnt", 32'(tx_flit_cnt), 0);

        // Credit exhaustion: 6 flits, 4 credits
        run_tx(6, 12, 16'h00A0, pulses);
        chk("tx_pulses", pulses, 4);
        chk("tx_stats", 32'(tx_flit_cnt), STATS ? 4 : 0);
        out_credit = 1'b1;
        tick();
        out_credit = 1'b0;
        chk("cr_ret_no_launch", 32'(out_data_valid), 0);
        tick();
        chk("cr_ret_launch", 32'(out_data_valid), 1);
        chk("cr_ret_data5", 32'(out_data), 32'h00A4);
        tick();
        chk("one_pulse", 32'(out_data_valid), 0);
        chk("data_hold", 32'(out_data), 32'h00A4);
        tick();
        chk("stall_6th", 32'(out_data_valid), 0);
        out_credit = 1'b1;
        tick();
        out_credit = 1'b0;
        tick();
        chk("launch_6th", 32'(out_data_valid), 1);
        chk("data_6th", 32'(out_data), 32'h00A5);

        // Simultaneous launch and credit return with credit = 1
        out_credit = 1'b1;
        tick();
        out_credit = 1'b0;
        tx_valid = 1'b1; tx_data = 16'h00B0;
        tick();
        tx_data = 16'h00B1; out_credit = 1'b1;
        tick();
        chk("sim_launch0", 32'(out_data_valid), 1);
        chk("sim_data0", 32'(out_data), 32'h00B0);
        tx_valid = 1'b0; out_credit = 1'b0;
        tick();
        chk("sim_launch1", 32'(out_data_valid), 1);
        chk("sim_data1", 32'(out_data), 32'h00B1);
        tx_valid = 1'b1; tx_data = 16'h00B2;
        tick();
        tx_valid = 1'b0;
        tick();
        chk("sim_credit_zero", 32'(out_data_valid), 0);
        chk("sim_no_err", 32'(err_credit_overflow), 0);

        // RX round trip
        in_data_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'h00C0 + 16'(i);
            tick();
            if (i == 0) begin
                chk("rx_lat1", 32'(rx_valid), 1);
                chk("rx_head", 32'(rx_data), 32'h00C0);
            end
        end
        in_data_valid = 1'b0;
        chk("rx_no_credit", 32'(in_credit), 0);
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rx_pop_data", 32'(rx_data), 32'h00C0 + 32'(i));
            tick();
            chk("rx_credit", 32'(in_credit), 1);
        end
        rx_ready = 1'b0;
        tick();
        chk("rx_credit_end", 32'(in_credit), 0);
        chk("rx_empty", 32'(rx_valid), 0);
        chk("rx_stats", 32'(rx_flit_cnt), STATS ? 3 : 0);

        // RX full: push+pop same edge is legal, push without pop drops
        in_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h00D0 + 16'(i);
            tick();
        end
        in_data = 16'h00D9; rx_ready = 1'b1;
        tick();
        chk("rx_full_pushpop", 32'(err_rx_overflow), 0);
        rx_ready = 1'b0; in_data = 16'h00D4;
        tick();
        in_data_valid = 1'b0;
        chk("rx_overflow", 32'(err_rx_overflow), 1);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("rx_ovf_data", 32'(rx_data), (i == 3) ? 32'h00D9 : 32'h00D1 + 32'(i));
            tick();
        end
        rx_ready = 1'b0;
        chk("rx_ovf_drained", 32'(rx_valid), 0);
        chk("rx_err_sticky", 32'(err_rx_overflow), 1);

        // Credit overflow right after reset; counter must stay at 4
        do_reset();
        out_credit = 1'b1;
        tick();
        out_credit = 1'b0;
        chk("cr_overflow", 32'(err_credit_overflow), 1);
        run_tx(5, 10, 16'h00E0, pulses);
        chk("cr_sat_pulses", pulses, 4);

        // Mid-traffic asynchronous reset
        in_data_valid = 1'b1; in_data = 16'h00F0;
        tx_valid = 1'b1; tx_data = 16'h00F0; out_credit = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_data_valid), 0);
        chk("ar_out_data", 32'(out_data), 0);
        chk("ar_rx_valid", 32'(rx_valid), 0);
        chk("ar_err_cr", 32'(err_credit_overflow), 0);
        chk("ar_err_rx", 32'(err_rx_overflow), 0);
        do_reset();
        run_tx(6, 12, 16'h0050, pulses);
        chk("ar_credit_reload", pulses, 4);
        chk("ar_tx_stats", 32'(tx_flit_cnt), STATS ? 4 : 0);

`ifdef ROUTER_ENDPOINT_STATS_EN
        // 65537 launches wrap the 16-bit counter to 1
        do_reset();
        tx_valid = 1'b1; tx_data = 16'h1234;
        tick();
        out_credit = 1'b1;
        for (int i = 0; i < 65537; i++)
            tick();
        tx_valid = 1'b0; out_credit = 1'b0;
        chk("stats_wrap", 32'(tx_flit_cnt), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
